// File: rtl/bus_seq_pkg.sv
// Shared types and helpers for the bus drive sequencer.
package bus_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DEAD  = 2'd1,
    DRIVE = 2'd2
  } seqState_e;

  localparam int unsigned TIMER_W     = 4;
  localparam int unsigned DRIVE_CNT_W = 4;

  // Bits needed to name one of n owners.
  function automatic int unsigned ownerWidth(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Request index carries one spare bit so out-of-range sources stay visible and can be flagged.
  function automatic int unsigned srcWidth(input int unsigned n);
    return ownerWidth(n) + 1;
  endfunction

  // Low bit of lane idx inside the flattened lane bus.
  function automatic int unsigned laneBase(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/bus_drive_sequencer_if.sv
// Request handshake and buffer-bank outputs of the bus drive sequencer.
interface bus_drive_sequencer_if #(
  parameter int unsigned NSRC  = 4,
  parameter int unsigned WIDTH = 8
);
  import bus_seq_pkg::*;

  localparam int unsigned OWN_W = ownerWidth(NSRC);
  localparam int unsigned SRC_W = srcWidth(NSRC);

  logic                    req_valid;
  logic                    req_ready;
  logic [SRC_W-1:0]        req_src;
  logic [WIDTH-1:0]        req_data;
  // Drop bus ownership; "release" itself is a reserved word.
  logic                    busRelease;
  logic [NSRC*WIDTH-1:0]   lanes;
  logic [NSRC-1:0]         nOE;
  logic [OWN_W-1:0]        owner;
  logic                    owner_vld;
  logic                    err;

  // Requester side.
  modport master (
    output req_valid, req_src, req_data, busRelease,
    input  req_ready, lanes, nOE, owner, owner_vld, err
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_src, req_data, busRelease,
    output req_ready, lanes, nOE, owner, owner_vld, err
  );

endinterface

// File: rtl/dead_timer.sv
// Loadable down-counter that times the all-disabled gap between bus owners.
module dead_timer
  import bus_seq_pkg::*;
(
  input  logic               clk,
  input  logic               nrst,
  input  logic               load,
  input  logic [TIMER_W-1:0] value,
  output logic               done
);

  logic [TIMER_W-1:0] count;

  // Count down to zero; done is registered and high while count equals 1.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count <= '0;
      done  <= 1'b0;
    end else if (load) begin
      count <= value;
      done  <= (value == TIMER_W'(1));
    end else if (count != '0) begin
      count <= count - TIMER_W'(1);
      done  <= (count == TIMER_W'(2));
    end
  end

endmodule

// File: rtl/bus_drive_sequencer.sv
// Break-before-make owner sequencer feeding a bank of tri-state bus buffers.
module bus_drive_sequencer
  import bus_seq_pkg::*;
#(
  parameter int unsigned NSRC        = 4,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEAD_CYCLES = 1,
  parameter int unsigned MIN_DRIVE   = 2
) (
  input  logic                  clk,
  input  logic                  nrst,
  bus_drive_sequencer_if.slave  bus
);

  localparam int unsigned OWN_W = ownerWidth(NSRC);
  localparam int unsigned SRC_W = srcWidth(NSRC);
  localparam logic [TIMER_W-1:0]     DEAD_LOAD = TIMER_W'(DEAD_CYCLES);
  localparam logic [DRIVE_CNT_W-1:0] DRIVE_MIN = DRIVE_CNT_W'(MIN_DRIVE);
  localparam seqState_e AFTER_GRANT = (DEAD_CYCLES == 0) ? DRIVE : DEAD;

  seqState_e                state;
  seqState_e                stateNext;
  logic [OWN_W-1:0]         ownerQ;
  logic [OWN_W-1:0]         ownerNext;
  logic [NSRC-1:0]          nOeQ;
  logic [NSRC-1:0]          nOeNext;
  logic                     ownerVldQ;
  logic                     ownerVldNext;
  logic                     errQ;
  logic                     errNext;
  logic [DRIVE_CNT_W-1:0]   driveCnt;
  logic [DRIVE_CNT_W-1:0]   driveCntNext;
  logic                     timerLoad;
  logic                     timerDone;
  logic [WIDTH-1:0]         laneMem [NSRC];

  logic srcOkC;
  logic sameSrcC;
  logic minMetC;
  logic readyC;
  logic acceptC;
  logic goodC;

  // Handshake decode: ready is combinational because release must block acceptance in the same cycle.
  assign srcOkC   = (bus.req_src < SRC_W'(NSRC));
  assign sameSrcC = srcOkC && (OWN_W'(bus.req_src) == ownerQ);
  assign minMetC  = (driveCnt >= DRIVE_MIN);
  assign readyC   = (state == IDLE)  ? !bus.busRelease :
                    (state == DRIVE) ? (!bus.busRelease && (sameSrcC || minMetC)) :
                                       1'b0;
  assign acceptC  = bus.req_valid && readyC;
  assign goodC    = acceptC && srcOkC;

  dead_timer uTimer (
    .clk   (clk),
    .nrst  (nrst),
    .load  (timerLoad),
    .value (DEAD_LOAD),
    .done  (timerDone)
  );

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state logic; release always wins over a pending or new owner.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (goodC) stateNext = AFTER_GRANT;
      end
      DEAD: begin
        if (bus.busRelease)  stateNext = IDLE;
        else if (timerDone)  stateNext = DRIVE;
      end
      DRIVE: begin
        if (bus.busRelease)            stateNext = IDLE;
        else if (goodC && !sameSrcC)   stateNext = AFTER_GRANT;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs, decoded from the next state.
  always_comb begin
    ownerNext    = ownerQ;
    ownerVldNext = 1'b0;
    errNext      = 1'b0;
    driveCntNext = '0;
    timerLoad    = 1'b0;
    nOeNext      = '1;

    if (goodC) ownerNext = OWN_W'(bus.req_src);
    errNext      = acceptC && !srcOkC;
    ownerVldNext = (stateNext == DRIVE);
    timerLoad    = (stateNext == DEAD) && (state != DEAD);

    if (stateNext == DRIVE) begin
      if ((state != DRIVE) || (goodC && !sameSrcC)) driveCntNext = DRIVE_CNT_W'(1);
      else if (driveCnt < DRIVE_MIN)                 driveCntNext = driveCnt + DRIVE_CNT_W'(1);
      else                                           driveCntNext = driveCnt;
    end

    for (int i = 0; i < NSRC; i++) begin
      nOeNext[i] = !((stateNext == DRIVE) && (ownerNext == OWN_W'(i)));
    end
  end

  // Output registers; reset forces every buffer off without waiting for a clock.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      nOeQ      <= '1;
      ownerQ    <= '0;
      ownerVldQ <= 1'b0;
      errQ      <= 1'b0;
      driveCnt  <= '0;
    end else begin
      nOeQ      <= nOeNext;
      ownerQ    <= ownerNext;
      ownerVldQ <= ownerVldNext;
      errQ      <= errNext;
      driveCnt  <= driveCntNext;
    end
  end

  // Lane register file: each lane holds its byte until its own source is accepted again.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < NSRC; i++) laneMem[i] <= '0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (goodC && (bus.req_src == SRC_W'(i))) laneMem[i] <= bus.req_data;
      end
    end
  end

  for (genvar g = 0; g < NSRC; g++) begin : gLane
    assign bus.lanes[laneBase(g, WIDTH) +: WIDTH] = laneMem[g];
  end

  assign bus.req_ready = readyC;
  assign bus.nOE       = nOeQ;
  assign bus.owner     = ownerQ;
  assign bus.owner_vld = ownerVldQ;
  assign bus.err       = errQ;

endmodule
